// File: rtl/periph_timer.sv
// -----------------------------------------------------------------------------
// periph_timer
//
// Memory-mapped timer and I/O peripheral on the CPU load/store bus. It answers
// the word-aligned addresses TIMER_BASE + 0x00 .. 0x18. Registers:
//   +0x00 TH      reload value (rw)
//   +0x04 TL      counter (rw)
//   +0x08 TCON    [0] enable, [1] irq enable, [2] irq status (rw)
//   +0x0C LED     [7:0] (rw)
//   +0x10 SWITCH  [7:0] synchronised switch input (ro)
//   +0x14 DIGI    [11:0] 7-segment drive (rw)
//   +0x18 SYSTICK free-running cycle counter (ro)
//
// Ports:
//   reset   async active-high reset, clears all state
//   clk     system clock
//   rd, wr  load / store strobes
//   addr    byte address (exact 32-bit decode)
//   wdata   store data
//   rdata   combinational load data, 0 unless rd and a mapped address
//   switch  external switches, asynchronous to clk
//   led     LED register
//   digi    7-segment drive register
//   irqout  interrupt request = TCON[1] & TCON[2]
// -----------------------------------------------------------------------------
module periph_timer #(
  parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam logic [31:0] ADDR_TH      = TIMER_BASE + 32'h00;
  localparam logic [31:0] ADDR_TL      = TIMER_BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON    = TIMER_BASE + 32'h08;
  localparam logic [31:0] ADDR_LED     = TIMER_BASE + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH  = TIMER_BASE + 32'h10;
  localparam logic [31:0] ADDR_DIGI    = TIMER_BASE + 32'h14;
  localparam logic [31:0] ADDR_SYSTICK = TIMER_BASE + 32'h18;

  logic [31:0] th_q,      th_d;
  logic [31:0] tl_q,      tl_d;
  logic [2:0]  tcon_q,    tcon_d;
  logic [7:0]  led_q,     led_d;
  logic [11:0] digi_q,    digi_d;
  logic [31:0] systick_q, systick_d;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;

  // Next state: hardware timer activity first, then a CPU write to the same
  // register overrides it entirely (lost status set, no increment, old TH
  // used for a coincident reload).
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        if (tcon_q[1]) begin
          tcon_d[2] = 1'b1;
        end
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end

    if (wr) begin
      case (addr)
        ADDR_TH:   th_d   = wdata;
        ADDR_TL:   tl_d   = wdata;
        ADDR_TCON: tcon_d = wdata[2:0];
        ADDR_LED:  led_d  = wdata[7:0];
        ADDR_DIGI: digi_d = wdata[11:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Read mux reflects pre-edge state, so a simultaneous rd/wr returns the
  // value before the write lands.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (addr)
        ADDR_TH:      rdata = th_q;
        ADDR_TL:      rdata = tl_q;
        ADDR_TCON:    rdata = {29'd0, tcon_q};
        ADDR_LED:     rdata = {24'd0, led_q};
        ADDR_SWITCH:  rdata = {24'd0, sw_sync_q};
        ADDR_DIGI:    rdata = {20'd0, digi_q};
        ADDR_SYSTICK: rdata = systick_q;
        default:      rdata = '0;
      endcase
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_periph_timer.sv
// -----------------------------------------------------------------------------
// tb_periph_timer
//
// Scoreboard bench: the driver applies one bus cycle at a time, asks a
// register-array reference model for the outputs expected in that cycle and
// queues them; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_periph_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch = '0;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  periph_timer #(.TIMER_BASE(BASE)) dut (
    .reset  (reset),
    .clk    (clk),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- reference model ----------------
  // Register file indexed by word offset: 0 TH, 1 TL, 2 TCON, 3 LED, 5 DIGI.
  // SWITCH comes from a history of values seen at clock edges, SYSTICK from
  // the number of edges since reset.
  logic [31:0] m_reg [7];
  int unsigned m_tick;
  logic [7:0]  m_sw_hist[$];
  logic [7:0]  sw_cur = '0;

  function automatic int reg_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE || off >= 32'd28 || a[1:0] != 2'b00) return -1;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input bit r);
    int idx;
    if (!r) return '0;
    idx = reg_idx(a);
    if (idx < 0) return '0;
    if (idx == 4) return (m_sw_hist.size() >= 2) ? {24'd0, m_sw_hist[1]} : 32'd0;
    if (idx == 6) return m_tick;
    return m_reg[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = '0;
    m_tick = 0;
    m_sw_hist.delete();
  endtask

  task automatic m_edge(input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] sw);
    logic [31:0] nxt [7];
    int idx;
    for (int i = 0; i < 7; i++) nxt[i] = m_reg[i];
    if (m_reg[2][0]) begin
      if (m_reg[1] == 32'hFFFF_FFFF) begin
        nxt[1] = m_reg[0];
        if (m_reg[2][1]) nxt[2] = m_reg[2] | 32'd4;
      end else begin
        nxt[1] = m_reg[1] + 32'd1;
      end
    end
    if (w) begin
      idx = reg_idx(a);
      case (idx)
        0, 1: nxt[idx] = wd;
        2:    nxt[2] = wd & 32'h7;
        3:    nxt[3] = wd & 32'hFF;
        5:    nxt[5] = wd & 32'hFFF;
        default: ;
      endcase
    end
    for (int i = 0; i < 7; i++) m_reg[i] = nxt[i];
    m_tick = m_tick + 1;
    m_sw_hist.push_front(sw);
    if (m_sw_hist.size() > 2) void'(m_sw_hist.pop_back());
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit rs, input bit r, input bit w,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; rd = r; wr = w; addr = a; wdata = wd; switch = sw_cur;
    if (rs) m_reset();
    e.addr  = a;
    e.rdata = m_read(a, r);
    e.led   = m_reg[3][7:0];
    e.digi  = m_reg[5][11:0];
    e.irq   = m_reg[2][1] & m_reg[2][2];
    sbq.push_back(e);
    if (!rs) m_edge(w, a, wd, sw_cur);
  endtask

  task automatic wreg(input logic [31:0] off, input logic [31:0] v);
    cyc(1'b0, 1'b0, 1'b1, BASE + off, v);
  endtask

  task automatic rreg(input logic [31:0] off);
    cyc(1'b0, 1'b1, 1'b0, BASE + off, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      if (rdata !== e.rdata) begin
        miscompares++;
        $display("FAIL rdata addr=%h got=%h exp=%h t=%0t", e.addr, rdata, e.rdata, $time);
      end
      if (led !== e.led) begin
        miscompares++;
        $display("FAIL led got=%h exp=%h t=%0t", led, e.led, $time);
      end
      if (digi !== e.digi) begin
        miscompares++;
        $display("FAIL digi got=%h exp=%h t=%0t", digi, e.digi, $time);
      end
      if (irqout !== e.irq) begin
        miscompares++;
        $display("FAIL irqout got=%b exp=%b t=%0t", irqout, e.irq, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] offs [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                             32'h1C, 32'h20, 32'h02, 32'h05, 32'h1000_0000,
                             32'hFFFF_FFFC};

  initial begin
    int t;
    m_reset();
    // Reset held: every register and an unmapped address read 0.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, BASE + offs[i], 32'h0);
    // Release; SYSTICK counts edges since release.
    for (int i = 0; i < 4; i++) rreg(32'h18);

    // Reload and interrupt.
    wreg(32'h00, 32'hFFFF_FFFC);
    wreg(32'h04, 32'hFFFF_FFFE);
    wreg(32'h08, 32'h3);
    for (int i = 0; i < 4; i++) rreg(32'h04);
    rreg(32'h08);
    for (int i = 0; i < 4; i++) rreg(32'h04);
    // Clear while counting.
    wreg(32'h08, 32'h3);
    rreg(32'h08);
    rreg(32'h04);
    // TCON write coincident with overflow loses the status set.
    wreg(32'h04, 32'hFFFF_FFFF);
    wreg(32'h08, 32'h3);
    rreg(32'h08);
    rreg(32'h04);
    // TH write coincident with overflow: reload uses old TH.
    wreg(32'h04, 32'hFFFF_FFFF);
    wreg(32'h00, 32'h0000_0005);
    rreg(32'h04);
    rreg(32'h00);
    wreg(32'h08, 32'h3);
    // TL write collides with increment.
    wreg(32'h04, 32'h0000_1234);
    rreg(32'h04);
    rreg(32'h04);
    // Simultaneous rd/wr returns pre-write value.
    cyc(1'b0, 1'b1, 1'b1, BASE + 32'h00, 32'hDEAD_BEEF);
    rreg(32'h00);

    // I/O registers.
    wreg(32'h0C, 32'hFFFF_FFA5);
    rreg(32'h0C);
    wreg(32'h14, 32'h0000_1F0F);
    rreg(32'h14);
    sw_cur = 8'h3C;
    for (int i = 0; i < 4; i++) rreg(32'h10);

    // Read-only and misaligned writes are ignored.
    wreg(32'h18, 32'h1234_5678);
    rreg(32'h18);
    wreg(32'h02, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 1'b0, BASE + 32'h02, 32'h0);
    rreg(32'h00);
    rreg(32'h0C);
    wreg(32'h10, 32'hFF);
    rreg(32'h10);

    // Reset mid-operation while counting; timer stays disabled afterwards.
    cyc(1'b1, 1'b1, 1'b0, BASE + 32'h04, 32'h0);
    for (int i = 0; i < 3; i++) rreg(32'h04);
    rreg(32'h08);
    rreg(32'h18);

    // Randomised traffic, biased toward overflow and interrupt activity.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] off, wd;
      bit r, w, rs;
      off = offs[$urandom_range(0, 12)];
      r   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      wd  = $urandom;
      if (off == 32'h04 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      if (off == 32'h00 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF8 | $urandom_range(0, 7);
      if (off == 32'h08 && $urandom_range(0, 2) != 0) wd = 32'h3 | ($urandom & 32'hFFFF_FFF4);
      if ($urandom_range(0, 15) == 0) sw_cur = 8'($urandom);
      cyc(rs, r, w, BASE + off, wd);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    t = 0;
    while (sbq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (sbq.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/periph_timer.md
# periph_timer

Memory-mapped timer and I/O peripheral on the single-cycle CPU's load/store bus. It sits beside the data memory: it receives the same read strobe, write strobe, byte address and write data, and it answers addresses in the 0x4000_0000 window. The CPU's load-data mux selects its `rdata` for that window. It provides a reloadable interval timer with an interrupt request, a free-running cycle counter, LED and 7-segment output registers, and a synchronised switch input.

## Interface
- `TIMER_BASE`, default 32'h4000_0000: base byte address of the register window.

- `reset`, input, 1: asynchronous, active-high; clears all state.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rd`, input, 1: load strobe.
- `wr`, input, 1: store strobe.
- `addr`, input, 32: byte address; must be word aligned.
- `wdata`, input, 32: store data.
- `rdata`, output, 32: load data; combinational.
- `switch`, input, 8: external switches; asynchronous to `clk`.
- `led`, output, 8: LED register.
- `digi`, output, 12: 7-segment drive register.
- `irqout`, output, 1: interrupt request to the CPU.

## Operation
- **Register map.** Offsets are from `TIMER_BASE`; decode is an exact 32-bit match.
  - 0x00 TH, 32-bit, read/write: reload value.
  - 0x04 TL, 32-bit, read/write: counter.
  - 0x08 TCON, bits [2:0], read/write:
    - bit0 = enable.
    - bit1 = interrupt enable.
    - bit2 = interrupt status.
  - 0x0C LED, bits [7:0], read/write.
  - 0x10 SWITCH, bits [7:0], read-only.
  - 0x14 DIGI, bits [11:0], read/write.
  - 0x18 SYSTICK, 32-bit, read-only.
- **Reads.**
  - `rdata` = selected register, zero-extended, when `rd` is high and the address matches.
  - Otherwise `rdata` = 0.
  - Unmapped, misaligned or out-of-window addresses read 0.
- **Writes.**
  - When `wr` is high and the address matches a writable register, that register loads `wdata` (truncated to its width) on the rising edge.
  - Writes to read-only or unmapped addresses are ignored.
- **Timer.** Each cycle with TCON[0] = 1:
  - If TL == 32'hFFFF_FFFF: TL ← TH, and TCON[2] ← 1 when TCON[1] = 1.
  - Otherwise TL ← TL + 1.
  - With TCON[0] = 0, TL holds.
- **Interrupt.**
  - `irqout` = TCON[1] & TCON[2]. It is registered-source combinational with no extra delay.
  - Software clears the request by writing TCON with bit2 = 0.
- **SYSTICK.** Increments by 1 every cycle regardless of TCON and wraps from 32'hFFFF_FFFF to 0.
- **SWITCH.** `switch` passes through a 2-flop synchroniser; the SWITCH register reads the second flop.
- **Priority.** When a CPU write and hardware activity hit the same register in the same cycle, the CPU write wins entirely:
  - TL write vs. increment/reload: the written value is loaded and there is no increment that cycle.
  - TCON write vs. status set: the written value is loaded; the overflow status set is lost.
  - A TH write during a TL overflow: the reload uses the old TH.
- **Simultaneous strobes.** `rd` and `wr` may be high together; `rdata` shows the pre-write value.

## Timing
- **Reset.** TH, TL, TCON, LED, DIGI, SYSTICK and both synchroniser stages all go to 0, so `led` = 0, `digi` = 0, `irqout` = 0, and `rdata` = 0 unless `rd` is high.
- **Reset mid-operation.** Asserting `reset` while counting clears all state immediately. The timer stays disabled after release.
- **Read latency.** 0 cycles; combinational from `rd`/`addr` and current register state.
- **Write latency.** Visible on outputs and reads in the cycle after the rising edge.
- **Timer enable.** The first increment occurs on the first rising edge after TCON[0] is written to 1.
- **Overflow period.** With TH = R, overflow occurs every 2^32 − R cycles while enabled.
- **Status and interrupt.** TCON[2] and `irqout` rise on the same edge as the reload.
- **Switch latency.** Two rising edges from a stable `switch` change to the SWITCH read value.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-cycle → all registers read 0, `led` = 0, `digi` = 0, `irqout` = 0. Read addr 0x4000_0020 with `rd` = 1 → `rdata` = 0.
- **Reload.** Write TH = 32'hFFFF_FFFC, TL = 32'hFFFF_FFFE, TCON = 3'b011. Then:
  - TL reads FFFF_FFFF after 1 edge.
  - FFFF_FFFC after 2 edges, with TCON = 3'b111 and `irqout` = 1.
  - The next overflow follows 4 cycles later.
- **Interrupt clear.** While `irqout` = 1, write TCON = 3'b011 → `irqout` = 0 next cycle and the timer keeps counting. On a cycle where the TCON write coincides with an overflow → TCON = 3'b011 and `irqout` stays 0.
- **Write/increment collision.** Timer enabled, write TL = 32'h0000_1234 → TL reads 1234 the next cycle and 1235 the cycle after.
- **I/O registers.**
  - Write LED = 32'hFFFF_FFA5 → `led` = 8'hA5.
  - Write DIGI = 32'h0000_1F0F → `digi` = 12'hF0F.
  - Drive `switch` = 8'h3C → SWITCH reads 0 after 1 edge and 8'h3C after 2 edges.
- **SYSTICK.** After reset release, read SYSTICK at cycle N → value N. Writes to 0x4000_0018 or to 0x4000_0002 (misaligned) are ignored and read 0 / do not disturb state.
